// File: rtl/instr_queue_pkg.sv
// rtl/instr_queue_pkg.sv - shared CPU fetch types and issue/fetch width defines
`ifndef ISSUE_NUM
`define ISSUE_NUM 2
`endif
`ifndef FETCH_NUM
`define FETCH_NUM 2
`endif

package cpu_defs;

  typedef logic [31:0] uint32_t;

  typedef struct packed {
    uint32_t    pc;
    uint32_t    instr;
    logic       iaddr_ex;
    logic [4:0] iaddr_exccode;
  } fetch_entry_t;

endpackage

// File: rtl/instr_queue_lane_compact.sv
// rtl/instr_queue_lane_compact.sv - packs set push lanes toward lane 0 and counts them
module lane_compact
  import cpu_defs::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]             valid,
  input  fetch_entry_t [N-1:0]     data,
  output fetch_entry_t [N-1:0]     packed_data,
  output logic [N-1:0]             packed_valid,
  output logic [$clog2(N+1)-1:0]   num
);

  localparam int KW = $clog2(N+1);

  always_comb begin
    packed_data  = '0;
    packed_valid = '0;
    num          = '0;
    // num doubles as the running rank of the next set lane
    for (int i = 0; i < N; i++) begin
      if (valid[i]) begin
        for (int j = 0; j < N; j++) begin
          if (KW'(j) == num) packed_data[j] = data[i];
        end
        num = num + 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      packed_valid[j] = (KW'(j) < num);
    end
  end

endmodule

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - multi-lane FWFT instruction queue between fetch and decode
module instr_queue
  import cpu_defs::*;
#(
  parameter int DEPTH     = 16,
  parameter int FETCH_NUM = `FETCH_NUM,
  parameter int ISSUE_NUM = `ISSUE_NUM
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [FETCH_NUM-1:0]            push_valid,
  input  fetch_entry_t [FETCH_NUM-1:0]    push_data,
  output logic                            full,
  input  logic [$clog2(ISSUE_NUM+1)-1:0]  pop_num,
  output logic [ISSUE_NUM-1:0]            pop_valid,
  output fetch_entry_t [ISSUE_NUM-1:0]    pop_data,
  output logic [$clog2(DEPTH):0]          count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = $clog2(FETCH_NUM + 1);

  fetch_entry_t                  mem [DEPTH];
  logic [PW-1:0]                 rd_ptr;
  logic [PW-1:0]                 wr_ptr;

  fetch_entry_t [FETCH_NUM-1:0]  wr_data;
  logic [FETCH_NUM-1:0]          wr_valid;
  logic [FW-1:0]                 wr_num;

  logic                          push_ok;
  logic [CW-1:0]                 pushed;
  logic [CW-1:0]                 eff_pop;

  lane_compact #(.N(FETCH_NUM)) u_compact (
    .valid        (push_valid),
    .data         (push_data),
    .packed_data  (wr_data),
    .packed_valid (wr_valid),
    .num          (wr_num)
  );

  assign full    = (CW'(DEPTH) - count) < CW'(FETCH_NUM);
  assign push_ok = !full && !flush;
  assign pushed  = push_ok ? CW'(wr_num) : '0;
  // Clip so a protocol-violating pop_num can never underflow count
  assign eff_pop = (CW'(pop_num) > count) ? count : CW'(pop_num);

  always_comb begin
    for (int i = 0; i < ISSUE_NUM; i++) begin
      pop_data[i]  = mem[rd_ptr + PW'(i)];
      pop_valid[i] = (count > CW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(pushed);
      rd_ptr <= rd_ptr + PW'(eff_pop);
      count  <= count + pushed - eff_pop;
    end
  end

  // Storage has no reset; occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      for (int j = 0; j < FETCH_NUM; j++) begin
        if (wr_valid[j]) mem[wr_ptr + PW'(j)] <= wr_data[j];
      end
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - directed and random checks of instr_queue against a queue model
module tb_instr_queue;
  import cpu_defs::*;

  localparam int DEPTH = 16;
  localparam int FN    = 2;
  localparam int IN    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [FN-1:0]     push_valid;
  fetch_entry_t [FN-1:0] push_data;
  logic              full;
  logic [1:0]        pop_num;
  logic [IN-1:0]     pop_valid;
  fetch_entry_t [IN-1:0] pop_data;
  logic [4:0]        count;

  int tests = 0;
  int fails = 0;
  logic [31:0] pc_ctr = 32'h0;
  fetch_entry_t q[$];

  instr_queue #(.DEPTH(DEPTH), .FETCH_NUM(FN), .ISSUE_NUM(IN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_data(push_data), .full(full),
    .pop_num(pop_num), .pop_valid(pop_valid), .pop_data(pop_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [IN-1:0] epv;
    for (int i = 0; i < IN; i++) epv[i] = (q.size() > i);
    chk({tag, ".count"}, 128'(count), 128'(q.size()));
    chk({tag, ".full"}, 128'(full), 128'((DEPTH - q.size()) < FN));
    chk({tag, ".pop_valid"}, 128'(pop_valid), 128'(epv));
    for (int i = 0; i < IN; i++) begin
      if (i < q.size()) chk({tag, ".pop_data"}, 128'(pop_data[i]), 128'(q[i]));
    end
  endtask

  task automatic step(input logic r, input logic f, input logic [FN-1:0] pv,
                      input logic [1:0] pn, input string tag);
    int sz;
    int ep;
    bit fm;
    rst = r; flush = f; push_valid = pv; pop_num = pn;
    for (int i = 0; i < FN; i++) begin
      push_data[i].pc            = pc_ctr;
      push_data[i].instr         = $urandom;
      push_data[i].iaddr_ex      = 1'($urandom);
      push_data[i].iaddr_exccode = 5'($urandom);
      pc_ctr += 32'd4;
    end
    @(posedge clk);
    if (r || f) begin
      q.delete();
    end else begin
      sz = q.size();
      fm = (DEPTH - sz) < FN;
      ep = (int'(pn) > sz) ? sz : int'(pn);
      repeat (ep) void'(q.pop_front());
      if (!fm) for (int i = 0; i < FN; i++) if (pv[i]) q.push_back(push_data[i]);
    end
    #1;
    check_model(tag);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push_valid = '0; pop_num = '0; push_data = '0;

    step(1, 0, 2'b00, 0, "reset");
    chk("reset.count0", 128'(count), 128'(0));

    pc_ctr = 32'h100;
    step(0, 0, 2'b11, 0, "first_push");
    chk("first_push.pc0", 128'(pop_data[0].pc), 128'(32'h100));
    chk("first_push.pc1", 128'(pop_data[1].pc), 128'(32'h104));

    repeat (7) step(0, 0, 2'b11, 0, "fill");
    chk("fill.full", 128'(full), 128'(1));
    pc_ctr = 32'h200;
    step(0, 0, 2'b01, 0, "fill_drop");
    chk("fill_drop.count", 128'(count), 128'(16));

    repeat (7) step(0, 0, 2'b00, 2, "drain");
    step(0, 0, 2'b11, 1, "wrap_enter");
    repeat (6) step(0, 0, 2'b11, 2, "wrap_stream");
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 2'b11, 2, "wrap_seq");
      chk("wrap_seq.pc_order", 128'(pop_data[1].pc - pop_data[0].pc), 128'(32'd4));
    end

    step(0, 0, 2'b00, 2, "to_one");
    chk("to_one.count", 128'(count), 128'(1));
    step(0, 0, 2'b11, 2, "simul");
    chk("simul.count", 128'(count), 128'(2));
    step(0, 0, 2'b00, 2, "empty");

    pc_ctr = 32'h2FC;
    step(0, 0, 2'b10, 0, "sparse");
    chk("sparse.pc", 128'(pop_data[0].pc), 128'(32'h300));
    chk("sparse.valid", 128'(pop_valid), 128'(2'b01));
    step(0, 0, 2'b00, 1, "sparse_pop");

    repeat (4) step(0, 0, 2'b11, 0, "pre_flush");
    step(0, 0, 2'b01, 0, "pre_flush9");
    chk("pre_flush.count", 128'(count), 128'(9));
    step(0, 1, 2'b11, 1, "flush");
    chk("flush.valid", 128'(pop_valid), 128'(0));
    pc_ctr = 32'h400;
    step(0, 0, 2'b01, 0, "post_flush");
    chk("post_flush.pc", 128'(pop_data[0].pc), 128'(32'h400));

    step(1, 1, 2'b11, 2, "rst_and_flush");

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
           FN'($urandom), 2'($urandom_range(0, 2)), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
